// File: rtl/dm_arbiter_if.sv
// Bus bundle for the data-memory arbiter. Holds the CPU M-stage access,
// the secondary DMA/loader/debug word port and the single data-memory port.
// The slave modport is the arbiter's view; the master modport is the view
// of everything around it (pipeline, DMA engine and the memory itself).
interface dm_arbiter_if;
    // CPU M-stage access
    logic        cpu_req;
    logic        cpu_we;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [3:0]  cpu_be;
    logic        int_req;
    logic        cpu_stall;

    // Secondary DMA word port
    logic        dma_req;
    logic        dma_we;
    logic [29:0] dma_addr;
    logic [31:0] dma_wd;
    logic [3:0]  dma_be;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;

    // Shared data-memory port
    logic [29:0] dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic        dm_memwr;
    logic [31:0] dm_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be, int_req,
        output cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wd, dma_be,
        output dma_gnt, dma_rdata, dma_rvalid,
        output dm_addr, dm_wd, dm_be, dm_memwr,
        input  dm_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be, int_req,
        input  cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wd, dma_be,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  dm_addr, dm_wd, dm_be, dm_memwr,
        output dm_rd
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU M stage
// and a secondary DMA word port. The CPU normally wins; a DMA slot lasts
// exactly one cycle and is always followed by a CPU cycle. CPU stores are
// masked while an interrupt is pending so an interrupted store never commits.
//
// Optional feature macro: DM_ARB_STARVE_EN
//   defined   - a saturating starvation counter forces a DMA slot after
//               MAX_WAIT consecutive blocked cycles (stalling the CPU once)
//   undefined - strict CPU priority, DMA only gets idle CPU cycles
module dm_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        gnt;
    logic        starve_hit;
    logic [31:0] rdata_q;
    logic        rvalid_q;

    // Reject a threshold the 8-bit counter cannot represent
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("dm_arbiter: MAX_WAIT must be in 1..255");
    end

`ifdef DM_ARB_STARVE_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    assign starve_hit = (wait_cnt >= WAIT_LIMIT);

    // Count consecutive cycles the DMA request is blocked by the CPU
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!bus.dma_req || next_state == S_DMA) begin
            wait_cnt <= '0;
        end else if (state == S_CPU && bus.cpu_req && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CPU;
        end else begin
            state <= next_state;
        end
    end

    // Port mux, write strobe, handshakes and next-state selection
    always_comb begin
        next_state   = S_CPU;
        gnt          = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.dm_addr  = bus.cpu_addr;
        bus.dm_wd    = bus.cpu_wd;
        bus.dm_be    = bus.cpu_be;
        bus.dm_memwr = 1'b0;
        case (state)
            S_CPU: begin
                bus.dm_memwr = bus.cpu_req & bus.cpu_we & ~bus.int_req;
                if (bus.dma_req && (!bus.cpu_req || starve_hit)) begin
                    next_state = S_DMA;
                end
            end
            S_DMA: begin
                bus.dm_addr   = bus.dma_addr;
                bus.dm_wd     = bus.dma_wd;
                bus.dm_be     = bus.dma_be;
                bus.dm_memwr  = bus.dma_req & bus.dma_we;
                gnt           = bus.dma_req;
                bus.cpu_stall = bus.cpu_req;
                next_state    = S_CPU;
            end
            default: begin
                next_state = S_CPU;
            end
        endcase
        if (reset) begin
            bus.dm_memwr  = 1'b0;
            gnt           = 1'b0;
            bus.cpu_stall = 1'b0;
            next_state    = S_CPU;
        end
    end

    // Capture DMA read data at the end of a granted read; pulse rvalid once
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= gnt & ~bus.dma_we;
            if (gnt && !bus.dma_we) begin
                rdata_q <= bus.dm_rd;
            end
        end
    end

    assign bus.dma_gnt    = gnt;
    assign bus.dma_rdata  = rdata_q;
    assign bus.dma_rvalid = rvalid_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios with literal expectations,
// then randomized traffic. A cycle-level reference model predicts every
// arbiter output from the arbitration rules, and a reference memory image
// predicts DMA read data independently of the memory the DUT writes.
module tb_dm_arbiter;

    localparam int MAX_WAIT = 8;
`ifdef DM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    dm_arbiter_if bus ();

    dm_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory seen by the DUT: combinational read, byte-enabled write
    logic [31:0] dm_mem [0:63] = '{default: 32'h0};

    always_comb bus.dm_rd = dm_mem[bus.dm_addr[5:0]];

    always @(posedge clk) begin
        if (bus.dm_memwr) begin
            dm_mem[bus.dm_addr[5:0]] <= merge(dm_mem[bus.dm_addr[5:0]], bus.dm_wd, bus.dm_be);
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: whether this cycle is a DMA slot, how long the DMA
    // has been blocked, and the expected registered read-back.
    bit          m_slot   = 1'b0;
    int          m_wait   = 0;
    logic [31:0] m_rdata  = 32'h0;
    bit          m_rvalid = 1'b0;
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};

    // Compare every cycle, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        logic        e_stall, e_gnt, e_wr, go;
        logic [29:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        e_stall = !reset && m_slot && bus.cpu_req;
        e_gnt   = !reset && m_slot && bus.dma_req;
        if (reset)       e_wr = 1'b0;
        else if (m_slot) e_wr = bus.dma_req && bus.dma_we;
        else             e_wr = bus.cpu_req && bus.cpu_we && !bus.int_req;
        e_addr = m_slot ? bus.dma_addr : bus.cpu_addr;
        e_wd   = m_slot ? bus.dma_wd   : bus.cpu_wd;
        e_be   = m_slot ? bus.dma_be   : bus.cpu_be;

        checkOutput("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        checkOutput("dma_gnt", 32'(bus.dma_gnt), 32'(e_gnt));
        checkOutput("dm_memwr", 32'(bus.dm_memwr), 32'(e_wr));
        checkOutput("dm_addr", 32'(bus.dm_addr), 32'(e_addr));
        checkOutput("dma_rvalid", 32'(bus.dma_rvalid), 32'(m_rvalid));
        checkOutput("dma_rdata", bus.dma_rdata, m_rdata);
        if (e_wr) begin
            checkOutput("dm_wd", bus.dm_wd, e_wd);
            checkOutput("dm_be", 32'(bus.dm_be), 32'(e_be));
        end

        if (reset) begin
            m_slot = 1'b0; m_wait = 0; m_rvalid = 1'b0; m_rdata = 32'h0;
        end else begin
            m_rvalid = e_gnt && !bus.dma_we;
            if (m_rvalid) m_rdata = ref_mem[bus.dma_addr[5:0]];
            if (e_wr) ref_mem[e_addr[5:0]] = merge(ref_mem[e_addr[5:0]], e_wd, e_be);
            if (m_slot) begin
                m_slot = 1'b0;
                if (!bus.dma_req) m_wait = 0;
            end else begin
                go = bus.dma_req && (!bus.cpu_req || (STARVE && m_wait >= MAX_WAIT));
                if (go) begin
                    m_slot = 1'b1;
                    m_wait = 0;
                end else if (!bus.dma_req) begin
                    m_wait = 0;
                end else if (bus.cpu_req && m_wait < 255) begin
                    m_wait = m_wait + 1;
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuDrive(input logic req, input logic we, input logic [29:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input logic intr);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
        bus.cpu_wd = wd; bus.cpu_be = be; bus.int_req = intr;
    endtask

    task automatic dmaDrive(input logic req, input logic we, input logic [29:0] addr,
                            input logic [31:0] wd, input logic [3:0] be);
        bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr;
        bus.dma_wd = wd; bus.dma_be = be;
    endtask

    // One DMA access with an idle CPU; bounded wait for the grant
    task automatic dmaAccess(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rd, output logic rv);
        int waited;
        bit got;
        waited = 0;
        got = 1'b0;
        nextCycle();
        cpuDrive(0, 0, 0, 0, 0, 0);
        dmaDrive(1, we, addr, wd, be);
        while (!got && waited < 50) begin
            @(negedge clk);
            if (bus.dma_gnt) got = 1'b1;
            waited++;
            nextCycle();
        end
        dmaDrive(0, 0, 0, 0, 0);
        checkOutput("dma_grant_timeout", 32'(got), 32'd1);
        @(negedge clk);
        rd = bus.dma_rdata;
        rv = bus.dma_rvalid;
    endtask

    // One cycle of random traffic with a well-behaved DMA master
    task automatic applyStimulus(inout bit pending, inout bit got_gnt);
        nextCycle();
        reset = ($urandom_range(0, 199) == 0);
        cpuDrive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 30'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
        if (!pending || got_gnt || $urandom_range(0, 15) == 0) begin
            pending = ($urandom_range(0, 2) != 0);
            dmaDrive(pending, $urandom_range(0, 1) == 1, 30'($urandom_range(0, 63)),
                     $urandom, 4'($urandom_range(0, 15)));
        end
        @(negedge clk);
        got_gnt = bus.dma_gnt;
    endtask

    // Directed scenarios followed by random traffic
    initial begin
        logic [31:0] rd;
        logic        rv;
        bit          pending, got_gnt, dma_on;
        int          first_gnt, n_gnt, n_stall, stall_cyc;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        cpuDrive(0, 0, 0, 0, 0, 0);
        dmaDrive(0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_stall", 32'(bus.cpu_stall), 32'd0);
        checkOutput("reset_gnt", 32'(bus.dma_gnt), 32'd0);
        checkOutput("reset_rvalid", 32'(bus.dma_rvalid), 32'd0);
        checkOutput("reset_rdata", bus.dma_rdata, 32'd0);
        checkOutput("reset_memwr", 32'(bus.dm_memwr), 32'd0);

        // Reset arriving during a DMA write slot to word 0x10
        nextCycle();
        dmaDrive(1, 1, 30'h10, 32'hCAFEF00D, 4'hF);
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_slot_memwr", 32'(bus.dm_memwr), 32'd0);
        checkOutput("rst_slot_gnt", 32'(bus.dma_gnt), 32'd0);
        nextCycle();
        reset = 1'b0;
        dmaDrive(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_after_gnt", 32'(bus.dma_gnt), 32'd0);
        checkOutput("rst_after_rvalid", 32'(bus.dma_rvalid), 32'd0);
        checkOutput("rst_after_rdata", bus.dma_rdata, 32'd0);
        checkOutput("rst_after_memwr", 32'(bus.dm_memwr), 32'd0);

        // DMA write with idle CPU: grant one cycle after the request
        nextCycle();
        dmaDrive(1, 1, 30'h4, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        checkOutput("wr_t_gnt", 32'(bus.dma_gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("wr_t1_gnt", 32'(bus.dma_gnt), 32'd1);
        checkOutput("wr_t1_memwr", 32'(bus.dm_memwr), 32'd1);
        nextCycle();
        dmaDrive(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wr_t2_rvalid", 32'(bus.dma_rvalid), 32'd0);

        // DMA read of word 0x4: rvalid and data two cycles after request
        nextCycle();
        dmaDrive(1, 0, 30'h4, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("rd_t_gnt", 32'(bus.dma_gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rd_t1_gnt", 32'(bus.dma_gnt), 32'd1);
        nextCycle();
        dmaDrive(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd_t2_rvalid", 32'(bus.dma_rvalid), 32'd1);
        checkOutput("rd_t2_rdata", bus.dma_rdata, 32'hDEADBEEF);

        // Word 0x10 must not have been written by the reset-aborted slot
        dmaAccess(0, 30'h10, 32'h0, 4'hF, rd, rv);
        checkOutput("rst_no_write_word10", rd, 32'h0);

        // CPU store masked by a pending interrupt
        nextCycle();
        cpuDrive(1, 1, 30'h8, 32'h12345678, 4'hF, 1);
        @(negedge clk);
        checkOutput("int_store_memwr", 32'(bus.dm_memwr), 32'd0);
        checkOutput("int_store_stall", 32'(bus.cpu_stall), 32'd0);
        dmaAccess(0, 30'h8, 32'h0, 4'hF, rd, rv);
        checkOutput("int_store_readback", rd, 32'h0);
        checkOutput("int_store_rvalid", 32'(rv), 32'd1);

        // Withdrawn DMA request: idle slot, FSM back on the CPU afterwards
        nextCycle();
        dmaDrive(1, 1, 30'h5, 32'h55, 4'hF);
        @(negedge clk);
        checkOutput("wd_t_gnt", 32'(bus.dma_gnt), 32'd0);
        nextCycle();
        dmaDrive(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wd_slot_gnt", 32'(bus.dma_gnt), 32'd0);
        checkOutput("wd_slot_memwr", 32'(bus.dm_memwr), 32'd0);
        nextCycle();
        cpuDrive(1, 1, 30'h6, 32'h66, 4'hF, 0);
        @(negedge clk);
        checkOutput("wd_after_rvalid", 32'(bus.dma_rvalid), 32'd0);
        checkOutput("wd_after_stall", 32'(bus.cpu_stall), 32'd0);
        checkOutput("wd_after_cpu_memwr", 32'(bus.dm_memwr), 32'd1);
        nextCycle();
        cpuDrive(0, 0, 0, 0, 0, 0);

        // Byte-lane DMA write merges into an existing word
        dmaAccess(1, 30'h11, 32'h11223344, 4'hF, rd, rv);
        dmaAccess(1, 30'h11, 32'h00AB0000, 4'b0100, rd, rv);
        dmaAccess(0, 30'h11, 32'h0, 4'hF, rd, rv);
        checkOutput("byte_lane_readback", rd, 32'h11AB3344);

        // Busy CPU for 20 cycles against a waiting DMA read
        nextCycle();
        first_gnt = -1; n_gnt = 0; n_stall = 0; stall_cyc = -1;
        dma_on = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c != 0) nextCycle();
            cpuDrive(1, 0, 30'h1, 32'h0, 4'hF, 0);
            dmaDrive(dma_on, 0, 30'h2, 32'h0, 4'hF);
            @(negedge clk);
            if (bus.dma_gnt) begin
                n_gnt++;
                if (first_gnt < 0) first_gnt = c;
                dma_on = 1'b0;
            end
            if (bus.cpu_stall) begin
                n_stall++;
                stall_cyc = c;
            end
        end
        if (STARVE) begin
            checkOutput("starve_first_gnt_cycle", 32'(first_gnt), 32'd9);
            checkOutput("starve_gnt_count", 32'(n_gnt), 32'd1);
            checkOutput("starve_stall_cycle", 32'(stall_cyc), 32'd9);
            checkOutput("starve_stall_count", 32'(n_stall), 32'd1);
        end else begin
            checkOutput("strict_gnt_count", 32'(n_gnt), 32'd0);
            checkOutput("strict_stall_count", 32'(n_stall), 32'd0);
        end
        nextCycle();
        cpuDrive(0, 0, 0, 0, 0, 0);
        dmaDrive(0, 0, 0, 0, 0);

        // Random traffic, checked cycle by cycle against the model
        pending = 1'b0;
        got_gnt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(pending, got_gnt);
        end
        nextCycle();
        reset = 1'b0;
        cpuDrive(0, 0, 0, 0, 0, 0);
        dmaDrive(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester access controller placed in front of the data memory. It shares the single DM port between the pipeline M stage and a secondary word-access port used by DMA/loader/debug. The CPU has priority. A starvation counter forces a DMA slot by stalling the pipeline for one cycle. CPU stores are suppressed while an interrupt request is pending, so an interrupted store never commits.

## Interface

Parameters:
- MAX_WAIT, default 8: number of consecutive blocked DMA cycles (1..255) before a DMA slot is forced.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  M stage performs a load or store this cycle
- cpu_we  in  1  M-stage access is a store
- cpu_addr  in  30  word address [31:2]
- cpu_wd  in  32  store data, already lane-aligned
- cpu_be  in  4  byte enables
- int_req  in  1  interrupt/exception pending; blocks CPU stores
- cpu_stall  out  1  M stage must hold; the DM port is not serving the CPU this cycle
- dma_req  in  1  DMA access request; held with its fields until dma_gnt
- dma_we  in  1  DMA access is a write
- dma_addr  in  30  DMA word address [31:2]
- dma_wd  in  32  DMA write data
- dma_be  in  4  DMA byte enables
- dma_gnt  out  1  one-cycle pulse: the DMA access is performed this cycle
- dma_rdata  out  32  registered read data of the last granted DMA access
- dma_rvalid  out  1  one-cycle pulse, cycle after dma_gnt
- dm_addr  out  30  to DM Addr[31:2]
- dm_wd  out  32  to DM WD
- dm_be  out  4  to DM BE
- dm_memwr  out  1  to DM MemWr
- dm_rd  in  32  DM RD (combinational read)

## Operation

- FSM with two states: S_CPU (reset state) and S_DMA.
- S_CPU:
  - DM fields are muxed from cpu_*.
  - dm_memwr = cpu_req & cpu_we & !int_req.
  - cpu_stall = 0; dma_gnt = 0.
  - Next state is S_DMA if dma_req & (!cpu_req | wait_cnt >= MAX_WAIT). Otherwise stay in S_CPU.
- S_DMA:
  - DM fields are muxed from dma_*.
  - dm_memwr = dma_req & dma_we. int_req is ignored for DMA.
  - dma_gnt = dma_req.
  - cpu_stall = cpu_req.
  - Always returns to S_CPU next cycle, giving at most one DMA access per slot and at least one CPU cycle between DMA slots.
- Withdrawn request: if dma_req drops before its slot, the S_DMA cycle is idle: no write, no gnt, no rvalid.
- wait_cnt, 8 bits, saturating:
  - Increments in S_CPU when dma_req & cpu_req.
  - Clears when dma_req = 0 or on entry to S_DMA.
- DMA read: when dma_gnt and !dma_we, dma_rdata <= dm_rd at the end of that cycle and dma_rvalid pulses for one cycle. For DMA writes, dma_rdata holds its previous value and dma_rvalid = 0.
- CPU read data is taken from dm_rd directly by the pipeline. It is valid only when cpu_stall = 0.
- While reset is high:
  - dm_memwr = 0, dma_gnt = 0, cpu_stall = 0.
  - Next state is S_CPU; wait_cnt, dma_rdata and dma_rvalid clear to 0.
  - A DMA slot in progress is dropped without a write.

## Timing

- Reset values: state S_CPU, cpu_stall 0, dma_gnt 0, dma_rvalid 0, dma_rdata 0, dm_memwr 0, wait_cnt 0.
- CPU access: zero added latency when not stalled; the DM write commits at the clk edge ending the cycle.
- DMA with idle CPU: dma_req rises in cycle t, dma_gnt in t+1, dma_rvalid and dma_rdata in t+2.
- DMA against continuously busy CPU: first grant in cycle t+MAX_WAIT+1. The CPU is stalled exactly one cycle per forced slot.
- Simultaneous cpu_req and an S_DMA slot: DMA wins and the CPU stalls. The CPU access is re-presented by the held pipeline next cycle.
- int_req only masks CPU writes in the same cycle. Loads and DMA are unaffected.

## Configuration

- DM_ARB_STARVE_EN defined: starvation counter and forced slots as described; MAX_WAIT is honoured.
- Not defined: no counter logic. S_CPU -> S_DMA only when dma_req & !cpu_req, giving strict CPU priority. DMA may starve indefinitely. cpu_stall can assert only if cpu_req rises during an already-entered S_DMA cycle.

## Test plan

- Reset: assert reset during an S_DMA slot with dma_we=1 to address 0x10 -> dm_memwr=0, no write, all outputs 0 the next cycle.
- Idle CPU, DMA write of 0xDEADBEEF to word 0x4 with be=1111, then a DMA read of word 0x4 -> gnt in t+1 of each request, rvalid with dma_rdata=0xDEADBEEF two cycles after the read request.
- CPU store with int_req=1 (cpu_addr=0x8, wd=0x12345678) -> dm_memwr=0; a later read of word 0x8 returns 0.
- cpu_req held high for 20 cycles with dma_req high, MAX_WAIT=8 -> dma_gnt and cpu_stall both high in exactly cycle 9; without DM_ARB_STARVE_EN, no gnt in any of the 20 cycles.
- dma_req withdrawn in the cycle the FSM enters S_DMA -> dma_gnt=0, dm_memwr=0, dma_rvalid never pulses, FSM returns to S_CPU.
- Byte-lane DMA write, be=0100 wd=0x00AB0000 onto word 0x11223344 -> readback 0x11AB3344.
